// File: rtl/pkt_merge_pkg.sv
// Shared types and constants for the pkt_merge egress merger: FSM encodings,
// write-side admission states and header constants used to build control packets.
package pkt_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FWD_DATA = 2'd1,
        ST_FWD_CTRL = 2'd2
    } state_e;

    typedef enum logic {
        WR_ACCEPT  = 1'b0,
        WR_DISCARD = 1'b1
    } wr_state_e;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPPROT_UDP    = 8'h11;
    localparam logic [15:0] CONTROL_PORT  = 16'hf2f1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pkt_merge_fifo.sv
// fallthrough_small_fifo: small first-word-fall-through FIFO; dout_o shows the head
// entry whenever empty_o is low. Synchronous active-low reset clears pointers only.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   count_q;
    logic                      do_wr;
    logic                      do_rd;

    // The count MSB is only ever set when the FIFO holds exactly DEPTH entries.
    assign full_o  = count_q[MAX_DEPTH_BITS];
    assign empty_o = (count_q == '0);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pkt_merge.sv
// pkt_merge: packet-granular merge of the data-path AXI stream and buffered control
// replies into one output stream. Define CTRL_STRICT_PRIO_EN to give control strict priority.
module pkt_merge
    import pkt_merge_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int CTRL_FIFO_DEPTH_BITS = 5,
    parameter int MAX_CTRL_BEATS       = 8
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
    input  logic                              ctrl_s_axis_tvalid,
    input  logic                              ctrl_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [15:0]                       ctrl_drop_cnt
);

    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int KW     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int FW     = DW + UW + KW + 1;
    localparam int DEPTH  = 1 << CTRL_FIFO_DEPTH_BITS;
    localparam int OCC_W  = CTRL_FIFO_DEPTH_BITS + 1;
    localparam int BEAT_W = $clog2(MAX_CTRL_BEATS + 1);

    localparam logic [OCC_W-1:0]  ROOM_LIMIT = OCC_W'(DEPTH - MAX_CTRL_BEATS);
    localparam logic [BEAT_W-1:0] LAST_IDX   = BEAT_W'(MAX_CTRL_BEATS - 1);

    // Handshake: a beat moves on any interface in a cycle where valid and ready are
    // both high at the rising edge; the control input has no ready, so every valid
    // beat is either written to the FIFO or discarded in that same cycle.

    // ---------------- control write side ----------------
    wr_state_e         wr_state_q, wr_state_d;
    logic [BEAT_W-1:0] wr_idx_q, wr_idx_d;
    logic [15:0]       drop_q, drop_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic          fifo_wr;
    logic          fifo_wr_last;
    logic          fifo_push;
    logic          fifo_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;
    logic          room;
    logic          force_last;

    logic          rd_last;
    logic [KW-1:0] rd_keep;
    logic [UW-1:0] rd_user;
    logic [DW-1:0] rd_data;

    // Admission reserves room for a worst-case packet up front, so an admitted
    // packet can never find the FIFO full part-way through.
    assign room       = (occ_q <= ROOM_LIMIT);
    assign force_last = (wr_idx_q == LAST_IDX);

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_idx_d     = wr_idx_q;
        drop_d       = drop_q;
        fifo_wr      = 1'b0;
        fifo_wr_last = 1'b0;
        if (ctrl_s_axis_tvalid) begin
            if (wr_state_q == WR_DISCARD) begin
                if (ctrl_s_axis_tlast) begin
                    wr_state_d = WR_ACCEPT;
                end
            end else if ((wr_idx_q == '0) && !room) begin
                drop_d = sat_inc16(drop_q);
                if (!ctrl_s_axis_tlast) begin
                    wr_state_d = WR_DISCARD;
                end
            end else begin
                fifo_wr      = 1'b1;
                fifo_wr_last = ctrl_s_axis_tlast || force_last;
                if (ctrl_s_axis_tlast) begin
                    wr_idx_d = '0;
                end else if (force_last) begin
                    wr_idx_d   = '0;
                    wr_state_d = WR_DISCARD;
                    drop_d     = sat_inc16(drop_q);
                end else begin
                    wr_idx_d = wr_idx_q + 1'b1;
                end
            end
        end
    end

    assign fifo_push = fifo_wr && !fifo_full;
    assign fifo_din  = {fifo_wr_last, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, ctrl_s_axis_tdata};
    assign {rd_last, rd_keep, rd_user, rd_data} = fifo_dout;

    always_comb begin
        occ_d     = occ_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({fifo_push, fifo_rd})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        case ({fifo_push && fifo_wr_last, fifo_rd && rd_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_state_q <= WR_ACCEPT;
            wr_idx_q   <= '0;
            drop_q     <= '0;
            occ_q      <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign ctrl_drop_cnt = drop_q;

    fallthrough_small_fifo #(
        .WIDTH          (FW),
        .MAX_DEPTH_BITS (CTRL_FIFO_DEPTH_BITS)
    ) u_ctrl_fifo (
        .clk     (clk),
        .rst_ni  (aresetn),
        .din_i   (fifo_din),
        .wr_en_i (fifo_wr),
        .rd_en_i (fifo_rd),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------- read side / arbitration ----------------
    state_e state_q;
    logic   slot_free;
    logic   data_pend;
    logic   ctrl_pend;
    logic   pick_ctrl;

    assign slot_free     = !m_axis_tvalid || m_axis_tready;
    assign data_pend     = s_axis_tvalid;
    assign ctrl_pend     = (pkt_cnt_q != '0);
    assign s_axis_tready = (state_q == ST_FWD_DATA) && slot_free;
    assign fifo_rd       = (state_q == ST_FWD_CTRL) && !fifo_empty && slot_free;

`ifdef CTRL_STRICT_PRIO_EN
    assign pick_ctrl = ctrl_pend;
`else
    logic rr_ctrl_q;  // set when the last packet forwarded came from the control FIFO

    assign pick_ctrl = ctrl_pend && (!data_pend || !rr_ctrl_q);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            rr_ctrl_q <= 1'b0;
        end else if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
            rr_ctrl_q <= 1'b0;
        end else if (fifo_rd && rd_last) begin
            rr_ctrl_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pick_ctrl) begin
                        state_q <= ST_FWD_CTRL;
                    end else if (data_pend) begin
                        state_q <= ST_FWD_DATA;
                    end
                end
                ST_FWD_DATA: begin
                    if (s_axis_tvalid && s_axis_tready) begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tkeep  <= s_axis_tkeep;
                        m_axis_tuser  <= s_axis_tuser;
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tvalid <= 1'b1;
                        if (s_axis_tlast) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_FWD_CTRL: begin
                    if (fifo_rd) begin
                        m_axis_tdata  <= rd_data;
                        m_axis_tkeep  <= rd_keep;
                        m_axis_tuser  <= rd_user;
                        m_axis_tlast  <= rd_last;
                        m_axis_tvalid <= 1'b1;
                        if (rd_last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_merge.sv
// Directed bench for pkt_merge: expected output beats are queued when stimulus is
// planned and compared in order as the merged stream emits them.
module tb_pkt_merge;
  import pkt_merge_pkg::*;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int BW = 1 + KW + UW + DW;

  logic          clk;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] ctrl_s_axis_tdata;
  logic [KW-1:0] ctrl_s_axis_tkeep;
  logic [UW-1:0] ctrl_s_axis_tuser;
  logic          ctrl_s_axis_tvalid;
  logic          ctrl_s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [15:0]   ctrl_drop_cnt;

  pkt_merge dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .ctrl_s_axis_tdata  (ctrl_s_axis_tdata),
    .ctrl_s_axis_tkeep  (ctrl_s_axis_tkeep),
    .ctrl_s_axis_tuser  (ctrl_s_axis_tuser),
    .ctrl_s_axis_tvalid (ctrl_s_axis_tvalid),
    .ctrl_s_axis_tlast  (ctrl_s_axis_tlast),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .ctrl_drop_cnt      (ctrl_drop_cnt)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  logic arm_lat = 1'b0;
  int  lat_cyc = 0;

  function automatic logic [BW-1:0] mk_beat(input logic [7:0] tag, input int idx,
                                             input logic last, input logic is_ctrl);
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic [7:0]    ix;
    ix = 8'(idx);
    d  = {8{tag, ix, 16'hA5C3}};
    if (is_ctrl && idx == 0) begin
      d[96 +: 16]  = ETH_TYPE_IPV4;
      d[184 +: 8]  = IPPROT_UDP;
      d[64 +: 16]  = CONTROL_PORT;
    end
    u = {4{ix, tag, 16'h5A3C}};
    k = '1;
    k = k >> ix[1:0];
    return {last, k, u, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] tag, input int n_out, input logic is_ctrl);
    for (int i = 0; i < n_out; i++) begin
      exp_q.push_back(mk_beat(tag, i, (i == n_out - 1), is_ctrl));
    end
  endtask

  // ---------------- output monitor ----------------
  task automatic monitor_loop();
    logic          stall = 1'b0;
    logic [BW-1:0] held  = '0;
    logic [BW-1:0] m_beat;
    logic [BW-1:0] e;
    forever begin
      @(negedge clk);
      m_beat = {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata};
      if (!aresetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_tests++;
          assert (m_axis_tvalid === 1'b1 && m_beat === held) else begin
            n_fail++;
            $error("FAIL stall_hold: observed valid=%0b beat=%0h expected valid=1 beat=%0h",
                   m_axis_tvalid, m_beat, held);
          end
        end
        if (m_axis_tvalid && !m_axis_tready) begin
          n_tests++;
          assert (s_axis_tready === 1'b0) else begin
            n_fail++;
            $error("FAIL stall_s_ready: observed=%0b expected=0", s_axis_tready);
          end
        end
        stall = m_axis_tvalid && !m_axis_tready;
        held  = m_beat;
        if (m_axis_tvalid && m_axis_tready) begin
          if (arm_lat) begin
            lat_cyc = cyc;
            arm_lat = 1'b0;
          end
          n_tests++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL out_unexpected: observed=%0h expected=none", m_beat);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            assert (m_beat === e) else begin
              n_fail++;
              $error("FAIL out_beat: observed=%0h expected=%0h", m_beat, e);
            end
          end
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_data(input logic [7:0] tag, input int n);
    logic ok;
    int   waitc;
    for (int i = 0; i < n; i++) begin
      {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata} = mk_beat(tag, i, (i == n - 1), 1'b0);
      s_axis_tvalid = 1'b1;
      ok    = 1'b0;
      waitc = 0;
      while (!ok && waitc < 300) begin
        @(negedge clk);
        ok = s_axis_tready;
        @(posedge clk);
        #1;
        waitc++;
      end
      check("data_accept", 32'(ok), 32'd1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_ctrl(input logic [7:0] tag, input int n);
    for (int i = 0; i < n; i++) begin
      {ctrl_s_axis_tlast, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, ctrl_s_axis_tdata} =
          mk_beat(tag, i, (i == n - 1), 1'b1);
      ctrl_s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1;
    end
    ctrl_s_axis_tvalid = 1'b0;
    ctrl_s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] ta;
    logic [7:0] tb;
    logic [7:0] tags [5];
    logic [3:0] pat;
    int         t_start;

    fork
      monitor_loop();
    join_none

    aresetn            = 1'b0;
    s_axis_tdata       = '0;
    s_axis_tkeep       = '0;
    s_axis_tuser       = '0;
    s_axis_tvalid      = 1'b0;
    s_axis_tlast       = 1'b0;
    ctrl_s_axis_tdata  = '0;
    ctrl_s_axis_tkeep  = '0;
    ctrl_s_axis_tuser  = '0;
    ctrl_s_axis_tvalid = 1'b0;
    ctrl_s_axis_tlast  = 1'b0;
    m_axis_tready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_m_tdata", 32'(|m_axis_tdata), 32'd0);
    check("rst_m_tkeep", 32'(|m_axis_tkeep), 32'd0);
    check("rst_m_tuser", 32'(|m_axis_tuser), 32'd0);
    check("rst_drop_cnt", 32'(ctrl_drop_cnt), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;

    // data only, 3 beats, 2-cycle latency
    ta = 8'($urandom_range(1, 255));
    push_exp(ta, 3, 1'b0);
    t_start = cyc;
    arm_lat = 1'b1;
    drive_data(ta, 3);
    wait_drain("t1_drain", 50);
    check("t1_latency", 32'(lat_cyc - t_start), 32'd2);
    check("t1_drop_cnt", 32'(ctrl_drop_cnt), 32'd0);

    // back-pressure during a data packet: ready 1,0,0,1 repeating
    ta  = 8'($urandom_range(1, 255));
    pat = 4'b1001;
    push_exp(ta, 4, 1'b0);
    fork
      drive_data(ta, 4);
      begin
        for (int i = 0; i < 12; i++) begin
          m_axis_tready = pat[i % 4];
          @(posedge clk);
          #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    wait_drain("t4_drain", 50);

    // contention with pointer at data: ctrl goes first in both modes
    ta = 8'($urandom_range(1, 255));
    tb = 8'($urandom_range(1, 255));
    push_exp(ta, 2, 1'b1);
    push_exp(tb, 3, 1'b0);
    send_ctrl(ta, 2);
    drive_data(tb, 3);
    wait_drain("t3a_drain", 80);

    // control only, 2 beats, held until its tlast has been written
    ta = 8'($urandom_range(1, 255));
    push_exp(ta, 2, 1'b1);
    send_ctrl(ta, 2);
    @(negedge clk);
    check("t2_wait_tlast", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk);
    #1;
    wait_drain("t2_drain", 50);
    check("t2_drop_cnt", 32'(ctrl_drop_cnt), 32'd0);

    // contention with pointer at ctrl: data first unless control has strict priority
    ta = 8'($urandom_range(1, 255));
    tb = 8'($urandom_range(1, 255));
`ifdef CTRL_STRICT_PRIO_EN
    push_exp(ta, 2, 1'b1);
    push_exp(tb, 3, 1'b0);
`else
    push_exp(tb, 3, 1'b0);
    push_exp(ta, 2, 1'b1);
`endif
    send_ctrl(ta, 2);
    drive_data(tb, 3);
    wait_drain("t3b_drain", 80);

    // overflow: five 8-beat control packets with the output stalled
    m_axis_tready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      tags[p] = 8'($urandom_range(1, 255));
      if (p < 4) push_exp(tags[p], 8, 1'b1);
    end
    for (int p = 0; p < 5; p++) begin
      send_ctrl(tags[p], 8);
    end
    @(negedge clk);
    check("t5_drop_cnt", 32'(ctrl_drop_cnt), 32'd1);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_drain("t5_drain", 200);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_no_extra", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk);
    #1;

    // oversize control packet: truncated to 8 beats, counted as a drop
    ta = 8'($urandom_range(1, 255));
    push_exp(ta, 8, 1'b1);
    send_ctrl(ta, 10);
    wait_drain("t6_drain", 80);
    check("t6_drop_cnt", 32'(ctrl_drop_cnt), 32'd2);

    // reset while a data packet and a control packet are both mid-flight
    m_axis_tready = 1'b0;
    ta = 8'($urandom_range(1, 255));
    {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata} = mk_beat(ta, 0, 1'b0, 1'b0);
    s_axis_tvalid = 1'b1;
    {ctrl_s_axis_tlast, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, ctrl_s_axis_tdata} = mk_beat(ta, 0, 1'b0, 1'b1);
    ctrl_s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    {ctrl_s_axis_tlast, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, ctrl_s_axis_tdata} = mk_beat(ta, 1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata} = mk_beat(ta, 1, 1'b0, 1'b0);
    ctrl_s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_pre_rst_busy", 32'(m_axis_tvalid), 32'd1);
    @(posedge clk);
    #1;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(negedge clk);
    check("t6_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_m_tdata", 32'(|m_axis_tdata), 32'd0);
    check("t6_rst_m_tkeep", 32'(|m_axis_tkeep), 32'd0);
    check("t6_rst_m_tuser", 32'(|m_axis_tuser), 32'd0);
    check("t6_rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check("t6_rst_drop_cnt", 32'(ctrl_drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    ta = 8'($urandom_range(1, 255));
    tb = 8'($urandom_range(1, 255));
    push_exp(ta, 2, 1'b1);
    push_exp(tb, 2, 1'b0);
    send_ctrl(ta, 2);
    drive_data(tb, 2);
    wait_drain("t6_post_rst_drain", 80);
    check("t6_post_rst_drop", 32'(ctrl_drop_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
